// File: rtl/mem_arb_pkg.sv
// Shared types and state encodings for the fetch/data memory-port arbiter.
// Round-robin arbitration is built only when MEM_ARB_ROUND_ROBIN_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        InstrBusy = 2'd1,
        DataBusy  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnInstr = 1'b0,
        OwnData  = 1'b1
    } arb_owner_e;

    localparam logic [1:0] ST_IDLE       = Idle;
    localparam logic [1:0] ST_INSTR_BUSY = InstrBusy;
    localparam logic [1:0] ST_DATA_BUSY  = DataBusy;

endpackage

// File: rtl/mem_arb_req_slot.sv
// Single-entry pending-request holder: captures a request pulse and keeps it
// until the owning transaction completes; a pulse while occupied is dropped.
module mem_arb_req_slot #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    clear,
    input  logic [ADDR_WIDTH-1:0]   load_addr,
    input  logic [DATA_WIDTH-1:0]   load_wdata,
    input  logic [DATA_WIDTH/8-1:0] load_wstrb,
    input  logic                    load_is_write,
    output logic                    pending,
    output logic                    overflow,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    req_is_write
);

    logic                    pending_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH/8-1:0] wstrb_reg;
    logic                    is_write_reg;

    assign pending  = pending_reg;
    assign overflow = load & pending_reg;

    // The request view bypasses the register so a same-cycle pulse can be granted at once.
    assign req_addr     = pending_reg ? addr_reg     : load_addr;
    assign req_wdata    = pending_reg ? wdata_reg    : load_wdata;
    assign req_wstrb    = pending_reg ? wstrb_reg    : load_wstrb;
    assign req_is_write = pending_reg ? is_write_reg : load_is_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg  <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            is_write_reg <= 1'b0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (load && !pending_reg) begin
            pending_reg  <= 1'b1;
            addr_reg     <= load_addr;
            wdata_reg    <= load_wdata;
            wstrb_reg    <= load_wstrb;
            is_write_reg <= load_is_write;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port memory.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority; default is data-first.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    input  logic                    imem_req_i,
    output logic [DATA_WIDTH-1:0]   imem_rdata_o,
    output logic                    imem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    input  logic                    dmem_read_i,
    input  logic                    dmem_write_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    err_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [1:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic [STRB_WIDTH-1:0] mem_wstrb_reg, mem_wstrb_next;
    logic                  mem_read_reg, mem_read_next;
    logic                  mem_write_reg, mem_write_next;
    logic [DATA_WIDTH-1:0] imem_rdata_reg, dmem_rdata_reg;
    logic                  err_reg, err_next;

    logic                  i_pending, i_overflow, i_is_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [STRB_WIDTH-1:0] i_wstrb;
    logic                  d_pending, d_overflow, d_is_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [STRB_WIDTH-1:0] d_wstrb;

    logic dmem_load, dmem_conflict;
    logic i_valid, d_valid, i_clear, d_clear;
    logic data_first, grant_i, grant_d;

    // A simultaneous read+write pulse is taken as a write.
    assign dmem_load     = dmem_read_i | dmem_write_i;
    assign dmem_conflict = dmem_read_i & dmem_write_i;

    assign i_clear = mem_ready_i && (state_reg == ST_INSTR_BUSY);
    assign d_clear = mem_ready_i && (state_reg == ST_DATA_BUSY);
    assign i_valid = i_pending | imem_req_i;
    assign d_valid = d_pending | dmem_load;

    mem_arb_req_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_instr_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (imem_req_i),
        .clear         (i_clear),
        .load_addr     (imem_addr_i),
        .load_wdata    ('0),
        .load_wstrb    ('0),
        .load_is_write (1'b0),
        .pending       (i_pending),
        .overflow      (i_overflow),
        .req_addr      (i_addr),
        .req_wdata     (i_wdata),
        .req_wstrb     (i_wstrb),
        .req_is_write  (i_is_write)
    );

    mem_arb_req_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_data_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (dmem_load),
        .clear         (d_clear),
        .load_addr     (dmem_addr_i),
        .load_wdata    (dmem_wdata_i),
        .load_wstrb    (dmem_wstrb_i),
        .load_is_write (dmem_write_i),
        .pending       (d_pending),
        .overflow      (d_overflow),
        .req_addr      (d_addr),
        .req_wdata     (d_wdata),
        .req_wstrb     (d_wstrb),
        .req_is_write  (d_is_write)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_e last_grant_reg;

    // Only contended grants move the pointer; uncontested ones leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= OwnInstr;
        end else if ((state_reg == ST_IDLE) && i_valid && d_valid) begin
            last_grant_reg <= grant_d ? OwnData : OwnInstr;
        end
    end

    assign data_first = (last_grant_reg == OwnInstr);
`else
    assign data_first = 1'b1;
`endif

    always_comb begin
        state_next     = state_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        grant_i        = 1'b0;
        grant_d        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (d_valid && (data_first || !i_valid)) begin
                    grant_d = 1'b1;
                end else if (i_valid) begin
                    grant_i = 1'b1;
                end
            end
            ST_INSTR_BUSY: begin
                if (mem_ready_i) begin
                    if (d_valid) grant_d = 1'b1;
                    else         state_next = ST_IDLE;
                end
            end
            ST_DATA_BUSY: begin
                if (mem_ready_i) begin
                    if (i_valid) grant_i = 1'b1;
                    else         state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (grant_d) begin
            state_next     = ST_DATA_BUSY;
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
            mem_wstrb_next = d_wstrb;
            mem_read_next  = !d_is_write;
            mem_write_next = d_is_write;
        end
        if (grant_i) begin
            state_next     = ST_INSTR_BUSY;
            mem_addr_next  = i_addr;
            mem_wdata_next = i_wdata;
            mem_wstrb_next = i_wstrb;
            mem_read_next  = !i_is_write;
            mem_write_next = i_is_write;
        end
    end

    // A completion with nothing in flight (including after a reset abort) is a violation.
    assign err_next = err_reg | i_overflow | d_overflow | dmem_conflict
                    | (mem_ready_i && (state_reg == ST_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wstrb_reg  <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            imem_rdata_reg <= '0;
            dmem_rdata_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            err_reg       <= err_next;
            if (i_clear) imem_rdata_reg <= mem_rdata_i;
            if (d_clear) dmem_rdata_reg <= mem_rdata_i;
        end
    end

    assign imem_ready_o = i_clear;
    assign dmem_ready_o = d_clear;
    assign imem_rdata_o = i_clear ? mem_rdata_i : imem_rdata_reg;
    assign dmem_rdata_o = d_clear ? mem_rdata_i : dmem_rdata_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;
    assign mem_wstrb_o  = mem_wstrb_reg;
    assign mem_read_o   = mem_read_reg;
    assign mem_write_o  = mem_write_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter; grant-order expectations
// follow MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        write;
    } mem_txn_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr_i;
    logic        imem_req_i;
    logic [31:0] imem_rdata_o;
    logic        imem_ready_o;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_wstrb_i;
    logic        dmem_read_i;
    logic        dmem_write_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_ready_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    mem_txn_t mem_q[$];
    bit       resp_q[$];   // 1 = data port owns the response

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr_i  (imem_addr_i),
        .imem_req_i   (imem_req_i),
        .imem_rdata_o (imem_rdata_o),
        .imem_ready_o (imem_ready_o),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_wstrb_i (dmem_wstrb_i),
        .dmem_read_i  (dmem_read_i),
        .dmem_write_i (dmem_write_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_ready_o (dmem_ready_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drop all single-cycle pulses.
    task automatic tick();
        @(negedge clk);
        imem_req_i   = 1'b0;
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        mem_ready_i  = 1'b0;
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_q.delete();
        resp_q.delete();
    endtask

    task automatic push_fetch(input logic [31:0] addr);
        mem_txn_t t;
        t.addr = addr; t.wdata = '0; t.wstrb = '0; t.write = 1'b0;
        mem_q.push_back(t);
        resp_q.push_back(1'b0);
    endtask

    task automatic push_data(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic write);
        mem_txn_t t;
        t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.write = write;
        mem_q.push_back(t);
        resp_q.push_back(1'b1);
    endtask

    // Wait (bounded) for the next memory strobe and compare it with the scoreboard head.
    task automatic expect_mem(input string tag, input int exp_wait);
        mem_txn_t e;
        int  w    = 0;
        bit  seen = 1'b0;
        while (!seen && w < 20) begin
            tick();
            #1;
            w++;
            if (mem_read_o || mem_write_o) seen = 1'b1;
        end
        chk1({tag, "_strobe_seen"}, seen, 1'b1);
        chk1({tag, "_queue_nonempty"}, mem_q.size() != 0, 1'b1);
        if (seen && mem_q.size() != 0) begin
            e = mem_q.pop_front();
            chk32({tag, "_latency"}, 32'(w), 32'(exp_wait));
            chk32({tag, "_addr"}, mem_addr_o, e.addr);
            chk1({tag, "_write"}, mem_write_o, e.write);
            chk1({tag, "_read"}, mem_read_o, !e.write);
            if (e.write) begin
                chk32({tag, "_wdata"}, mem_wdata_o, e.wdata);
                chk32({tag, "_wstrb"}, 32'(mem_wstrb_o), 32'(e.wstrb));
            end
            $display("mem txn %s addr=%h write=%b wdata=%h wstrb=%h", tag,
                     mem_addr_o, mem_write_o, mem_wdata_o, mem_wstrb_o);
        end
    endtask

    // Pulse mem_ready_i and check the response goes only to the expected owner.
    task automatic respond(input string tag, input logic [31:0] rd);
        bit own_d;
        tick();
        mem_ready_i = 1'b1;
        mem_rdata_i = rd;
        #1;
        chk1({tag, "_resp_expected"}, resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
            own_d = resp_q.pop_front();
            chk1({tag, "_imem_ready"}, imem_ready_o, !own_d);
            chk1({tag, "_dmem_ready"}, dmem_ready_o, own_d);
            chk32({tag, "_rdata"}, own_d ? dmem_rdata_o : imem_rdata_o, rd);
            $display("resp %s owner=%s rdata=%h", tag, own_d ? "data" : "instr", rd);
        end
    endtask

    logic [5:0] order;

    initial begin
        rst_n        = 1'b0;
        imem_addr_i  = '0;
        imem_req_i   = 1'b0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        dmem_wstrb_i = '0;
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        mem_rdata_i  = '0;
        mem_ready_i  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        order = 6'b011001;   // bit i = 1: i-th grant goes to data (D,I,I,D,D,I)
`else
        order = 6'b010101;   // D,I,D,I,D,I
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rst_mem_read", mem_read_o, 1'b0);
        chk1("rst_mem_write", mem_write_o, 1'b0);
        chk32("rst_mem_addr", mem_addr_o, 32'h0);
        chk1("rst_err", err_o, 1'b0);
        chk32("rst_imem_rdata", imem_rdata_o, 32'h0);
        chk32("rst_dmem_rdata", dmem_rdata_o, 32'h0);

        // Single fetch: ready three cycles after the request.
        tick();
        imem_req_i = 1'b1; imem_addr_i = 32'h100;
        push_fetch(32'h100);
        expect_mem("fetch", 1);
        tick(); #1;
        chk1("fetch_busy_no_strobe", mem_read_o, 1'b0);
        chk32("fetch_busy_addr_hold", mem_addr_o, 32'h100);
        respond("fetch", 32'h00500093);
        tick(); #1;
        chk1("fetch_ready_one_cycle", imem_ready_o, 1'b0);
        chk32("fetch_rdata_hold", imem_rdata_o, 32'h00500093);

        // Store with partial strobes.
        tick();
        dmem_write_i = 1'b1; dmem_addr_i = 32'h2004;
        dmem_wdata_i = 32'hDEADBEEF; dmem_wstrb_i = 4'h3;
        push_data(32'h2004, 32'hDEADBEEF, 4'h3, 1'b1);
        expect_mem("store", 1);
        respond("store", 32'h0);

        // Three simultaneous fetch+load pairs; the first is the 0x104/0x2000 collision.
        for (int k = 0; k < 3; k++) begin
            tick();
            imem_req_i = 1'b1;  imem_addr_i = 32'h104 + 32'(k * 4);
            dmem_read_i = 1'b1; dmem_addr_i = 32'h2000 + 32'(k * 4);
            for (int j = 0; j < 2; j++) begin
                if (order[2 * k + j]) push_data(32'h2000 + 32'(k * 4), 32'h0, 4'h0, 1'b0);
                else                  push_fetch(32'h104 + 32'(k * 4));
            end
            expect_mem("pair_first", 1);
            respond("pair_first", 32'h11110000 + 32'(k));
            expect_mem("pair_second", 1);
            respond("pair_second", 32'h22220000 + 32'(k));
        end
        tick(); #1;
        chk1("no_err_clean_traffic", err_o, 1'b0);

        // Duplicate fetch while one is in flight is dropped and flagged.
        tick();
        imem_req_i = 1'b1; imem_addr_i = 32'h200;
        push_fetch(32'h200);
        expect_mem("dup_fetch", 1);
        tick();
        imem_req_i = 1'b1; imem_addr_i = 32'h300;
        tick(); #1;
        chk1("dup_err_set", err_o, 1'b1);
        respond("dup_fetch", 32'h33333333);
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk1("dup_dropped_no_strobe", mem_read_o, 1'b0);
        end
        chk1("dup_err_sticky", err_o, 1'b1);

        // Stray ready in Idle.
        apply_reset();
        #1;
        chk1("rst2_err_cleared", err_o, 1'b0);
        tick();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h55555555;
        #1;
        chk1("stray_no_imem_ready", imem_ready_o, 1'b0);
        chk1("stray_no_dmem_ready", dmem_ready_o, 1'b0);
        tick(); #1;
        chk1("stray_err_set", err_o, 1'b1);

        // Read and write together: issued as a write, flagged.
        apply_reset();
        tick();
        dmem_read_i = 1'b1; dmem_write_i = 1'b1; dmem_addr_i = 32'h3000;
        dmem_wdata_i = 32'hCAFEF00D; dmem_wstrb_i = 4'hF;
        push_data(32'h3000, 32'hCAFEF00D, 4'hF, 1'b1);
        expect_mem("rw_both", 1);
        chk1("rw_both_err", err_o, 1'b1);
        respond("rw_both", 32'h0);

        // Reset mid-load, then a late completion for the aborted access.
        apply_reset();
        tick();
        dmem_read_i = 1'b1; dmem_addr_i = 32'h2008;
        push_data(32'h2008, 32'h0, 4'h0, 1'b0);
        expect_mem("abort_load", 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("abort_rst_mem_read", mem_read_o, 1'b0);
        chk32("abort_rst_mem_addr", mem_addr_o, 32'h0);
        chk1("abort_rst_err", err_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_ready_i = 1'b1; mem_rdata_i = 32'hABCD1234;
        #1;
        chk1("abort_no_dmem_ready", dmem_ready_o, 1'b0);
        chk1("abort_no_imem_ready", imem_ready_o, 1'b0);
        tick(); #1;
        chk1("abort_stray_err", err_o, 1'b1);
        chk32("abort_dmem_rdata_zero", dmem_rdata_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
